// File: rtl/fwperiph_dma_pkg.sv
// Shared constants and types for the fwperiph DMA channel arbiter.
package fwperiph_dma_pkg;

    localparam int unsigned FWPERIPH_DMA_CH_IDX_W = 5;
    localparam int unsigned FWPERIPH_DMA_PRI_W    = 2;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StStart    = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } arb_state_e;

endpackage

// File: rtl/fwperiph_dma_ch_arb_if.sv
// Channel-arbiter bus: channel request side plus the shared engine handshake.
// master: the arbiter. slave: the register file / engine / monitor side.
interface fwperiph_dma_ch_arb_if #(
    parameter int unsigned ch_count = 4
);
    import fwperiph_dma_pkg::*;

    logic [ch_count-1:0]                   ch_req;
    logic [ch_count-1:0]                   ch_en;
    logic [FWPERIPH_DMA_PRI_W*ch_count-1:0] ch_pri;
    logic [FWPERIPH_DMA_CH_IDX_W-1:0]      ch_sel;
    logic                                  dma_start;
    logic                                  dma_busy;
    logic [ch_count-1:0]                   ch_done;
    logic                                  arb_active;

    modport master (
        input  ch_req, ch_en, ch_pri, dma_busy,
        output ch_sel, dma_start, ch_done, arb_active
    );

    modport slave (
        output ch_req, ch_en, ch_pri, dma_busy,
        input  ch_sel, dma_start, ch_done, arb_active
    );

endinterface

// File: rtl/fwperiph_dma_rr_pick.sv
// Combinational rotating picker: first set bit of mask_i at or after ptr_i,
// wrapping to bit 0. ptr_i must be below ch_count.
module fwperiph_dma_rr_pick
    import fwperiph_dma_pkg::*;
#(
    parameter int unsigned ch_count = 4
) (
    input  logic [ch_count-1:0]              mask_i,
    input  logic [FWPERIPH_DMA_CH_IDX_W-1:0] ptr_i,
    output logic [FWPERIPH_DMA_CH_IDX_W-1:0] idx_o,
    output logic                             valid_o
);

    logic [FWPERIPH_DMA_CH_IDX_W-1:0] hi_idx;
    logic [FWPERIPH_DMA_CH_IDX_W-1:0] lo_idx;
    logic                             hi_valid;

    // Lowest set bit at/above the pointer beats the lowest set bit below it.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_valid = 1'b0;
        // Descending scan: the last hit in each half is its lowest index.
        for (int i = ch_count - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                if (i >= int'(ptr_i)) begin
                    hi_idx   = FWPERIPH_DMA_CH_IDX_W'(i);
                    hi_valid = 1'b1;
                end else begin
                    lo_idx = FWPERIPH_DMA_CH_IDX_W'(i);
                end
            end
        end
        valid_o = |mask_i;
        idx_o   = hi_valid ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/fwperiph_dma_ch_arb.sv
// DMA channel arbiter/sequencer: grants one channel to the shared engine,
// pulses dma_start, follows dma_busy to completion and pulses ch_done.
// Optional feature: define FWPERIPH_DMA_ARB_PRIORITY_EN to honour ch_pri;
// otherwise selection is pure round-robin and ch_pri is ignored.
module fwperiph_dma_ch_arb
    import fwperiph_dma_pkg::*;
#(
    parameter int unsigned ch_count = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    fwperiph_dma_ch_arb_if.master bus
);

    arb_state_e                       state_q, state_d;
    logic [FWPERIPH_DMA_CH_IDX_W-1:0] ch_sel_q, ch_sel_d;
    logic [FWPERIPH_DMA_CH_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ch_count-1:0]              ch_done_q, ch_done_d;

    logic [ch_count-1:0]              eligible;
    logic [ch_count-1:0]              pick_mask;
    logic [FWPERIPH_DMA_CH_IDX_W-1:0] pick_idx;
    logic                             pick_valid;

    // The channel just completed sits out the done cycle so it can drop ch_req.
    assign eligible = bus.ch_req & bus.ch_en & ~ch_done_q;

`ifdef FWPERIPH_DMA_ARB_PRIORITY_EN
    logic [FWPERIPH_DMA_PRI_W-1:0] max_pri;

    // Reduce the eligible set to the channels at the highest requested priority.
    always_comb begin
        max_pri   = '0;
        pick_mask = '0;
        for (int i = 0; i < ch_count; i++) begin
            if (eligible[i] && (bus.ch_pri[FWPERIPH_DMA_PRI_W*i +: FWPERIPH_DMA_PRI_W] > max_pri)) begin
                max_pri = bus.ch_pri[FWPERIPH_DMA_PRI_W*i +: FWPERIPH_DMA_PRI_W];
            end
        end
        for (int i = 0; i < ch_count; i++) begin
            if (eligible[i] && (bus.ch_pri[FWPERIPH_DMA_PRI_W*i +: FWPERIPH_DMA_PRI_W] == max_pri)) begin
                pick_mask[i] = 1'b1;
            end
        end
    end
`else
    assign pick_mask = eligible;
`endif

    fwperiph_dma_rr_pick #(
        .ch_count (ch_count)
    ) u_rr_pick (
        .mask_i  (pick_mask),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Next-state logic: grant in idle, then start, wait for busy, wait for idle engine.
    always_comb begin
        state_d   = state_q;
        ch_sel_d  = ch_sel_q;
        rr_ptr_d  = rr_ptr_q;
        ch_done_d = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    ch_sel_d = pick_idx;
                    state_d  = StStart;
                end
            end
            StStart: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (bus.dma_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!bus.dma_busy) begin
                    ch_done_d = ch_count'(1) << ch_sel_q;
                    // Wraps to 0; with a single channel this keeps the pointer at 0.
                    if (ch_sel_q == FWPERIPH_DMA_CH_IDX_W'(ch_count - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = ch_sel_q + FWPERIPH_DMA_CH_IDX_W'(1);
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any transfer without telling the engine.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ch_sel_q  <= '0;
            rr_ptr_q  <= '0;
            ch_done_q <= '0;
        end else begin
            state_q   <= state_d;
            ch_sel_q  <= ch_sel_d;
            rr_ptr_q  <= rr_ptr_d;
            ch_done_q <= ch_done_d;
        end
    end

    assign bus.ch_sel     = ch_sel_q;
    assign bus.ch_done    = ch_done_q;
    assign bus.dma_start  = (state_q == StStart);
    assign bus.arb_active = (state_q != StIdle);

endmodule

// File: tb/tb_fwperiph_dma_ch_arb.sv
// Self-checking bench for fwperiph_dma_ch_arb (4 channels): a vector table,
// hand sequences for done overlap and mid-transfer reset, and random traffic
// against a transaction-level selection model. Follows the
// FWPERIPH_DMA_ARB_PRIORITY_EN setting of the build.
module tb_fwperiph_dma_ch_arb;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fwperiph_dma_ch_arb_if #(.ch_count(N)) bus_if ();

    fwperiph_dma_ch_arb #(
        .ch_count (N)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: round-robin start point, last granted channel, excluded channel.
    int           model_ptr  = 0;
    int           model_sel  = 0;
    logic [N-1:0] model_excl = '0;

    typedef struct {
        logic [N-1:0]   req;
        logic [N-1:0]   en;
        logic [2*N-1:0] pri;
        bit             start;
        int             sel_rr;
        int             sel_pri;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Winner = highest priority; ties go to the first channel met walking from ptr.
    function automatic int pick_ref(input logic [N-1:0] req, input logic [N-1:0] en,
                                    input logic [2*N-1:0] pri, input logic [N-1:0] excl,
                                    input int ptr);
        int best = -1;
        int best_p = -1;
        for (int off = 0; off < N; off++) begin
            int c;
            int p;
            c = (ptr + off) % N;
            p = 0;
`ifdef FWPERIPH_DMA_ARB_PRIORITY_EN
            p = int'(pri[2*c +: 2]);
`endif
            if (req[c] && en[c] && !excl[c] && p > best_p) begin
                best   = c;
                best_p = p;
            end
        end
        return best;
    endfunction

    task automatic arb(input logic [N-1:0] req, input logic [N-1:0] en,
                       input logic [2*N-1:0] pri, output int w);
        bus_if.ch_req = req;
        bus_if.ch_en  = en;
        bus_if.ch_pri = pri;
        w = pick_ref(req, en, pri, model_excl, model_ptr);
        tick();
        model_excl = '0;
        check("arb_start", 32'(bus_if.dma_start), 32'(w >= 0));
        check("arb_active", 32'(bus_if.arb_active), 32'(w >= 0));
        if (w >= 0) model_sel = w;
        check("arb_sel", 32'(bus_if.ch_sel), 32'(model_sel));
    endtask

    // Called in the START cycle. Engine idles for lo cycles, is busy for hi cycles.
    // Returns in the ch_done cycle.
    task automatic xfer(input int w, input int lo, input int hi, input bit scramble);
        bit           b[16];
        int           i_hi;
        int           j_lo;
        int           done_k;
        logic [N-1:0] oh;
        oh = N'(1) << w;
        if (lo + hi < 2) hi = 2 - lo;
        for (int k = 0; k < 16; k++) b[k] = (k >= lo) && (k < lo + hi);
        // Busy only counts once seen after START; done follows its first low afterwards.
        i_hi = -1;
        for (int k = 1; k < 16; k++) if (b[k] && i_hi < 0) i_hi = k;
        j_lo = -1;
        for (int k = i_hi + 1; k < 16; k++) if (!b[k] && j_lo < 0) j_lo = k;
        done_k = j_lo + 1;
        bus_if.dma_busy = b[0];
        tick();
        for (int k = 1; k <= done_k; k++) begin
            if (k < done_k) begin
                check("xfer_start_low", 32'(bus_if.dma_start), 32'd0);
                check("xfer_active", 32'(bus_if.arb_active), 32'd1);
                check("xfer_no_done", 32'(bus_if.ch_done), 32'd0);
            end else begin
                check("xfer_done", 32'(bus_if.ch_done), 32'(oh));
                check("xfer_idle", 32'(bus_if.arb_active), 32'd0);
                check("xfer_done_start_low", 32'(bus_if.dma_start), 32'd0);
            end
            check("xfer_sel_hold", 32'(bus_if.ch_sel), 32'(w));
            bus_if.dma_busy = b[k];
            if (scramble && k < done_k) begin
                bus_if.ch_en  = N'($urandom) & ~oh;
                bus_if.ch_req = N'($urandom) | oh;
                bus_if.ch_pri = (2 * N)'($urandom);
            end
            if (k < done_k) tick();
        end
        model_ptr  = (w + 1) % N;
        model_excl = oh;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           w;
        int           exp_sel;
        logic [N-1:0] r;
        logic [N-1:0] e;

        tbl[0]  = '{4'b0010, 4'b1111, 8'h00, 1'b1, 1, 1};
        tbl[1]  = '{4'b1111, 4'b0100, 8'h00, 1'b1, 2, 2};
        tbl[2]  = '{4'b1111, 4'b1111, 8'hF1, 1'b1, 3, 3};
        tbl[3]  = '{4'b1111, 4'b1111, 8'hF1, 1'b1, 0, 2};
        tbl[4]  = '{4'b1001, 4'b1111, 8'hF1, 1'b1, 3, 3};
        tbl[5]  = '{4'b0001, 4'b1111, 8'hF1, 1'b1, 0, 0};
        tbl[6]  = '{4'b1111, 4'b0000, 8'h00, 1'b0, 0, 0};
        tbl[7]  = '{4'b0000, 4'b1111, 8'h00, 1'b0, 0, 0};
        tbl[8]  = '{4'b0110, 4'b1111, 8'h18, 1'b1, 1, 1};
        tbl[9]  = '{4'b0110, 4'b1111, 8'h18, 1'b1, 2, 1};
        tbl[10] = '{4'b1100, 4'b1111, 8'h00, 1'b1, 3, 2};

        bus_if.ch_req   = '1;
        bus_if.ch_en    = '1;
        bus_if.ch_pri   = '0;
        bus_if.dma_busy = 1'b0;

        // Reset with requests pending: nothing may be granted.
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sel", 32'(bus_if.ch_sel), 32'd0);
        check("rst_start", 32'(bus_if.dma_start), 32'd0);
        check("rst_done", 32'(bus_if.ch_done), 32'd0);
        check("rst_active", 32'(bus_if.arb_active), 32'd0);
        bus_if.ch_req = '0;
        rst_n = 1'b1;

        // Vector table, starting from rr_ptr = 0.
        for (int i = 0; i < 11; i++) begin
`ifdef FWPERIPH_DMA_ARB_PRIORITY_EN
            exp_sel = tbl[i].sel_pri;
`else
            exp_sel = tbl[i].sel_rr;
`endif
            bus_if.ch_req = tbl[i].req;
            bus_if.ch_en  = tbl[i].en;
            bus_if.ch_pri = tbl[i].pri;
            tick();
            model_excl = '0;
            check("tbl_start", 32'(bus_if.dma_start), 32'(tbl[i].start));
            if (tbl[i].start) begin
                check("tbl_sel", 32'(bus_if.ch_sel), 32'(exp_sel));
                model_sel = exp_sel;
                xfer(exp_sel, 1, 2, 1'b1);
            end else begin
                check("tbl_sel_hold", 32'(bus_if.ch_sel), 32'(model_sel));
            end
            bus_if.ch_req = '0;
            bus_if.ch_en  = '0;
            tick();
            model_excl = '0;
        end

        // Done overlap: ch1 keeps requesting through its ch_done; zero-length wait.
        arb(4'b0010, 4'b1111, 8'h00, w);
        if (w >= 0) xfer(w, 0, 3, 1'b0);
        arb(4'b0010, 4'b1111, 8'h00, w);
        arb(4'b0010, 4'b1111, 8'h00, w);
        if (w >= 0) xfer(w, 2, 1, 1'b0);

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            r = N'($urandom);
            e = N'($urandom) | N'($urandom);
            arb(r, e, (2 * N)'($urandom), w);
            if (w >= 0) xfer(w, $urandom_range(0, 3), $urandom_range(1, 4), 1'b1);
        end

        // Reset in WAIT_DONE, then arbitration restarts from ch0.
        bus_if.ch_req = '0;
        tick();
        model_excl = '0;
        arb(4'b0100, 4'b1111, 8'h00, w);
        bus_if.dma_busy = 1'b1;
        tick();
        tick();
        check("midrst_pre_active", 32'(bus_if.arb_active), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sel", 32'(bus_if.ch_sel), 32'd0);
        check("midrst_active", 32'(bus_if.arb_active), 32'd0);
        check("midrst_start", 32'(bus_if.dma_start), 32'd0);
        check("midrst_done", 32'(bus_if.ch_done), 32'd0);
        bus_if.dma_busy = 1'b0;
        bus_if.ch_req   = '0;
        tick();
        check("midrst_no_done", 32'(bus_if.ch_done), 32'd0);
        rst_n      = 1'b1;
        model_ptr  = 0;
        model_sel  = 0;
        model_excl = '0;
        arb(4'b1111, 4'b1111, 8'h00, w);
        check("midrst_restart_ch0", 32'(bus_if.ch_sel), 32'd0);
        if (w >= 0) xfer(w, 1, 1, 1'b0);
        arb(4'b1110, 4'b1111, 8'h00, w);
        if (w >= 0) xfer(w, 1, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
